// File: rtl/ahb_sram_bridge.sv
`timescale 1ns/1ps
// ahb_sram_bridge: AHB-Lite slave that turns bus transfers into accesses on a
// single-port synchronous SRAM. It handles byte lanes, defers a read that
// collides with a pending write by one cycle, and gives a two-cycle ERROR
// response for misaligned, oversized or out-of-range transfers.
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   HSEL..HREADY        AHB-Lite slave inputs (address phase + HWDATA)
//   HRDATA, HREADYOUT,  AHB-Lite slave response
//   HRESP
//   sram_cen/wen/ben    SRAM controls, active low
//   sram_addr/din/dout  SRAM word address, write data, read data (1-cycle latency)
module ahb_sram_bridge #(
    parameter int unsigned MEM_BYTES = 32'd67108864,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [3:0]        sram_ben,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    localparam int unsigned CMP_W = ADDR_W + 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_RD_DEFER,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;

    logic              accept;
    logic              legal;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        wr_ben;
    logic              unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign word_addr      = {HADDR[ADDR_W-1:2], 2'b00};

    // Nothing is sampled while this slave is stalling the bus.
    assign accept = HSEL && HTRANS[1] && HREADY &&
                    (state_q != ST_RD_DEFER) && (state_q != ST_ERR1);

    // Transfer legality: size, alignment and range.
    always_comb begin
        legal = 1'b1;
        if (HSIZE > 3'd2)                              legal = 1'b0;
        if ((HSIZE == 3'd1) && HADDR[0])               legal = 1'b0;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))  legal = 1'b0;
        if (CMP_W'(HADDR) >= CMP_W'(MEM_BYTES))        legal = 1'b0;
    end

    // Byte-lane enables for the latched write.
    always_comb begin
        wr_ben = 4'b0000;
        case (size_q)
            2'd0:    wr_ben = ~(4'b0001 << off_q);
            2'd1:    wr_ben = off_q[1] ? 4'b0011 : 4'b1100;
            default: wr_ben = 4'b0000;
        endcase
    end

    // Next data-phase state and address-phase latches.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        off_d   = off_q;
        case (state_q)
            ST_RD_DEFER: state_d = ST_RD_DATA;
            ST_ERR1:     state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (HWRITE) begin
                        state_d = ST_WR_DATA;
                        addr_d  = word_addr;
                        size_d  = HSIZE[1:0];
                        off_d   = HADDR[1:0];
                    end else if (state_q == ST_WR_DATA) begin
                        // Port is busy with the write this cycle; read next cycle.
                        state_d = ST_RD_DEFER;
                        addr_d  = word_addr;
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end
            end
        endcase
    end

    // Bus response and SRAM port; everything idles while HRESET is high.
    always_comb begin
        HRDATA    = 32'h0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = 4'hF;
        sram_addr = '0;
        sram_din  = 32'h0;
        if (!HRESET) begin
            case (state_q)
                ST_WR_DATA: begin
                    sram_cen  = 1'b0;
                    sram_wen  = 1'b0;
                    sram_ben  = wr_ben;
                    sram_addr = addr_q;
                    sram_din  = HWDATA;
                end
                ST_RD_DEFER: begin
                    sram_cen  = 1'b0;
                    sram_ben  = 4'h0;
                    sram_addr = addr_q;
                    HREADYOUT = 1'b0;
                end
                ST_RD_DATA: HRDATA = sram_dout;
                ST_ERR1: begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end
                ST_ERR2:    HRESP = 1'b1;
                default:    ;
            endcase
            if ((state_q != ST_WR_DATA) && accept && legal && !HWRITE) begin
                sram_cen  = 1'b0;
                sram_ben  = 4'h0;
                sram_addr = word_addr;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            off_q   <= off_d;
        end
    end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
`timescale 1ns/1ps
// tb_ahb_sram_bridge: directed and random AHB-Lite traffic against the bridge,
// with a behavioural SRAM macro and a byte-array reference memory.
module tb_ahb_sram_bridge;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_BYTES = 32'd67108864;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'h0;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;

    logic [31:0] sram_mem [0:4095] = '{default: 32'h0};
    logic [7:0]  ref_mem  [0:16383] = '{default: 8'h0};

    int n_tests = 0;
    int n_fail  = 0;
    int cen_cnt = 0;

    // Transfer currently in its data phase.
    logic        pend_v = 1'b0;
    logic        pend_w = 1'b0;
    logic [2:0]  pend_sz = 3'd0;
    logic [31:0] pend_a = 32'h0;
    logic [31:0] pend_wd = 32'h0;
    logic        pend_err = 1'b0;
    logic        pend_defer = 1'b0;

    int          last_waits = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        cap_cen, cap_wen;
    logic [3:0]  cap_ben;
    logic [31:0] cap_addr, cap_din;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_sram_bridge #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) dut (
        .HCLK     (hclk),
        .HRESET   (hreset),
        .HSEL     (hsel),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADY   (hready),
        .HRDATA   (hrdata),
        .HREADYOUT(hreadyout),
        .HRESP    (hresp),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_ben (sram_ben),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    // Synchronous SRAM macro, 16 KB window at address 0.
    always @(posedge hclk) begin
        if (!sram_cen && (sram_addr < 32'h4000)) begin
            if (!sram_wen) begin
                for (int i = 0; i < 4; i++)
                    if (!sram_ben[i])
                        sram_mem[sram_addr[13:2]][8*i +: 8] <= sram_din[8*i +: 8];
            end else begin
                sram_dout <= sram_mem[sram_addr[13:2]];
            end
        end
    end

    always @(negedge hclk) if (!sram_cen) cen_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [13:0] b;
        b = 14'(a & 32'hFFFF_FFFC);
        return {ref_mem[b + 14'd3], ref_mem[b + 14'd2], ref_mem[b + 14'd1], ref_mem[b]};
    endfunction

    function automatic logic lane_on(input logic [2:0] sz, input logic [1:0] off, input int i);
        case (sz)
            3'd0:    return (i == int'(off));
            3'd1:    return (i == int'(off)) || (i == int'(off) + 1);
            default: return 1'b1;
        endcase
    endfunction

    // Data phase of the pending transfer finishes this cycle.
    task automatic complete(input int waits);
        logic [13:0] base;
        check("resp", 32'(hresp), 32'(pend_err));
        check("waits", 32'(waits), (pend_err || pend_defer) ? 32'd1 : 32'd0);
        if (!pend_err && !pend_w) begin
            check("rdata", hrdata, ref_word(pend_a));
        end else begin
            check("rdata_zero", hrdata, 32'h0);
        end
        if (!pend_err && pend_w) begin
            base = 14'(pend_a & 32'hFFFF_FFFC);
            for (int i = 0; i < 4; i++)
                if (lane_on(pend_sz, pend_a[1:0], i))
                    ref_mem[base + 14'(i)] = pend_wd[8*i +: 8];
        end
    endtask

    // One bus slot: present an address phase (or IDLE) while the pending
    // transfer runs its data phase; returns once the slot is accepted.
    task automatic step(input logic v, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic err);
        int   waits;
        logic done;
        logic first;
        hsel   = v;
        htrans = v ? 2'b10 : 2'b00;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        hwdata = (pend_v && pend_w) ? pend_wd : 32'h0;
        waits  = 0;
        done   = 1'b0;
        first  = 1'b1;
        while (!done) begin
            @(negedge hclk);
            if (first) begin
                cap_cen  = sram_cen;
                cap_wen  = sram_wen;
                cap_ben  = sram_ben;
                cap_addr = sram_addr;
                cap_din  = sram_din;
                first    = 1'b0;
            end
            if (hreadyout) begin
                done       = 1'b1;
                last_rdata = hrdata;
                if (pend_v) complete(waits);
            end else begin
                waits++;
                if (pend_v && pend_err) check("err1_resp", 32'(hresp), 32'd1);
                if (waits > 4) begin
                    check("wait_bound", 32'(waits), 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge hclk);
            #1;
        end
        pend_defer = v && !w && pend_v && pend_w && !pend_err;
        pend_v     = v;
        pend_w     = w;
        pend_sz    = sz;
        pend_a     = a;
        pend_wd    = wd;
        pend_err   = err;
        last_waits = waits;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        int cen_before;

        // Reset state
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_cen", 32'(sram_cen), 32'd1);
        check("rst_wen", 32'(sram_wen), 32'd1);
        check("rst_ben", 32'(sram_ben), 32'hF);
        check("rst_addr", sram_addr, 32'h0);
        check("rst_din", sram_din, 32'h0);
        @(posedge hclk);
        #1;

        // 1: word write then immediate read -> one deferred wait state
        step(1'b1, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        check("t1_cen", 32'(cap_cen), 32'd0);
        check("t1_wen", 32'(cap_wen), 32'd0);
        check("t1_ben", 32'(cap_ben), 32'h0);
        check("t1_addr", cap_addr, 32'h100);
        check("t1_din", cap_din, 32'hDEAD_BEEF);
        idle();
        check("t1_waits", 32'(last_waits), 32'd1);
        check("t1_rdata", last_rdata, 32'hDEAD_BEEF);

        // 2: byte write into lane 3, idle gap, then read
        step(1'b1, 1'b1, 3'd2, 32'h100, 32'h1122_3344, 1'b0);
        step(1'b1, 1'b1, 3'd0, 32'h103, 32'hAA00_0000, 1'b0);
        idle();
        check("t2_ben", 32'(cap_ben), 32'h7);
        step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        idle();
        check("t2_waits", 32'(last_waits), 32'd0);
        check("t2_rdata", last_rdata, 32'hAA22_3344);

        // 3: half write to upper half, then back-to-back reads
        step(1'b1, 1'b1, 3'd2, 32'h204, 32'h0102_0304, 1'b0);
        step(1'b1, 1'b1, 3'd1, 32'h202, 32'hBEEF_0000, 1'b0);
        idle();
        check("t3_ben", 32'(cap_ben), 32'h3);
        step(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 1'b0);
        step(1'b1, 1'b0, 3'd2, 32'h204, 32'h0, 1'b0);
        check("t3_waits_a", 32'(last_waits), 32'd0);
        check("t3_rdata_a", last_rdata, 32'hBEEF_0000);
        idle();
        check("t3_waits_b", 32'(last_waits), 32'd0);
        check("t3_rdata_b", last_rdata, 32'h0102_0304);

        // 4: illegal transfers -> two-cycle ERROR, no SRAM activity
        cen_before = cen_cnt;
        step(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 1'b1);
        idle();
        check("t4_misaligned_word_waits", 32'(last_waits), 32'd1);
        step(1'b1, 1'b1, 3'd1, 32'h3, 32'hFFFF_FFFF, 1'b1);
        idle();
        check("t4_misaligned_half_waits", 32'(last_waits), 32'd1);
        step(1'b1, 1'b0, 3'd2, 32'(MEM_BYTES), 32'h0, 1'b1);
        idle();
        check("t4_range_waits", 32'(last_waits), 32'd1);
        step(1'b1, 1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF, 1'b1);
        idle();
        check("t4_no_sram_access", 32'(cen_cnt - cen_before), 32'd0);
        step(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
        idle();
        check("t4_mem_unchanged", last_rdata, 32'h0);
        // read accepted during the second error cycle
        step(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 1'b1);
        step(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        idle();
        check("t4_err2_read", last_rdata, 32'hAA22_3344);

        // 5: reset during a write data phase abandons the write
        step(1'b1, 1'b1, 3'd2, 32'h40, 32'h5566_7788, 1'b0);
        idle();
        step(1'b1, 1'b1, 3'd2, 32'h40, 32'h9999_9999, 1'b0);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h9999_9999;
        hreset = 1'b1;
        @(negedge hclk);
        check("t5_cen_in_reset", 32'(sram_cen), 32'd1);
        @(posedge hclk);
        #1 hreset = 1'b0;
        pend_v = 1'b0;
        @(negedge hclk);
        check("t5_hreadyout", 32'(hreadyout), 32'd1);
        check("t5_hresp", 32'(hresp), 32'd0);
        check("t5_hrdata", hrdata, 32'h0);
        check("t5_cen", 32'(sram_cen), 32'd1);
        check("t5_ben", 32'(sram_ben), 32'hF);
        check("t5_addr", sram_addr, 32'h0);
        check("t5_din", sram_din, 32'h0);
        @(posedge hclk);
        #1;
        step(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
        idle();
        check("t5_mem_unchanged", last_rdata, 32'h5566_7788);

        // 6: random legal traffic against the byte-array model
        for (int n = 0; n < 1000; n++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            logic        w;
            if ($urandom_range(0, 3) == 0) idle();
            sz = 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 1023));
            a  = a & ~((32'd1 << sz) - 32'd1);
            w  = 1'($urandom_range(0, 1));
            step(1'b1, w, sz, a, $urandom(), 1'b0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
